// File: rtl/clz_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined leading-zero/one counter.
// Optional normalised output is enabled by defining CLZ_PIPE_NORM_EN.
package clz_pipe_pkg;

  localparam logic CLZ_MODE_ZEROS = 1'b0;
  localparam logic CLZ_MODE_ONES  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Merge level lvl (0..levels-1) is registered in this stage; the last level always lands in stages-1.
  function automatic int level_stage(input int lvl, input int levels, input int stages);
    return (lvl * stages) / levels;
  endfunction

endpackage

// File: rtl/clz_pipe_stage.sv
// One valid/ready register slice of the counter pipeline; ready_i is this slice's own
// load permission (empty, or downstream taking the current entry this cycle).
module clz_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic          ready_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_i) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/clz_pipe.sv
// Pipelined leading-zero/one counter: a log2(WIDTH)-level merge tree cut into STAGES slices.
// Define CLZ_PIPE_NORM_EN to add out_norm (operand shifted left by the count).
module clz_pipe
  import clz_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_mode,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [clog2(WIDTH)-1:0]   out_count,
  output logic                      out_all,
  output logic [TAG_W-1:0]          out_tag
`ifdef CLZ_PIPE_NORM_EN
  ,
  output logic [WIDTH-1:0]          out_norm
`endif
);

  localparam int LW = clog2(WIDTH);

  logic [WIDTH-1:0]  opnd;
  logic [STAGES-1:0] stg_vq;
  logic [STAGES:0]   vchain;
  logic [STAGES:0]   stg_rdy;
  logic [TAG_W-1:0]  tag_arr [STAGES+1];
`ifdef CLZ_PIPE_NORM_EN
  logic [WIDTH-1:0]  opd_arr [STAGES+1];
  assign opd_arr[0] = in_data;
`endif

  // Ones mode is handled by inverting up front; the tree only ever counts zeros.
  always_comb begin
    opnd = in_data;
    case (in_mode)
      CLZ_MODE_ZEROS: opnd = in_data;
      CLZ_MODE_ONES:  opnd = ~in_data;
      default:        opnd = in_data;
    endcase
  end

  assign vchain = {stg_vq, in_valid};

  always_comb begin
    stg_rdy         = '0;
    stg_rdy[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) stg_rdy[s] = !stg_vq[s] || stg_rdy[s+1];
  end

  assign in_ready   = stg_rdy[0];
  assign tag_arr[0] = in_tag;

  genvar gi, gj;
  for (gi = 0; gi < LW; gi++) begin : g_lvl
    localparam int  N   = WIDTH >> (gi + 1);
    localparam int  PW  = gi + 1;
    localparam int  STG = level_stage(gi, LW, STAGES);
    localparam bit  REG = (gi == LW - 1) || (level_stage(gi + 1, LW, STAGES) != STG);

    logic [N-1:0]    v;
    logic [N*PW-1:0] p;

    if (gi == 0) begin : g_leaf
      for (gj = 0; gj < N; gj++) begin : g_node
        assign v[gj] = opnd[2*gj+1] | opnd[2*gj];
        assign p[gj] = ~opnd[2*gj+1];
      end
    end else begin : g_merge
      localparam bit PREV_REG = (level_stage(gi - 1, LW, STAGES) != STG);
      logic [2*N-1:0]    sv;
      logic [2*N*gi-1:0] sp;
      if (PREV_REG) begin : g_src_reg
        assign sv = g_lvl[gi-1].g_reg.q_v;
        assign sp = g_lvl[gi-1].g_reg.q_p;
      end else begin : g_src_comb
        assign sv = g_lvl[gi-1].v;
        assign sp = g_lvl[gi-1].p;
      end
      // Odd node is the more significant half; its zeros win if it holds any one.
      for (gj = 0; gj < N; gj++) begin : g_node
        assign v[gj] = sv[2*gj+1] | sv[2*gj];
        assign p[gj*PW +: PW] = sv[2*gj+1] ? {1'b0, sp[(2*gj+1)*gi +: gi]}
                                           : {1'b1, sp[(2*gj)*gi +: gi]};
      end
    end

    if (REG) begin : g_reg
`ifdef CLZ_PIPE_NORM_EN
      localparam int DW = N + N * PW + TAG_W + WIDTH;
`else
      localparam int DW = N + N * PW + TAG_W;
`endif
      logic [N-1:0]    q_v;
      logic [N*PW-1:0] q_p;
      logic [DW-1:0]   d_in, d_out;

`ifdef CLZ_PIPE_NORM_EN
      assign d_in = {tag_arr[STG], opd_arr[STG], v, p};
      assign {tag_arr[STG+1], opd_arr[STG+1], q_v, q_p} = d_out;
`else
      assign d_in = {tag_arr[STG], v, p};
      assign {tag_arr[STG+1], q_v, q_p} = d_out;
`endif

      clz_pipe_stage #(.DW(DW)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (vchain[STG]),
        .ready_i (stg_rdy[STG]),
        .data_i  (d_in),
        .valid_o (stg_vq[STG]),
        .data_o  (d_out)
      );
    end
  end

  assign out_valid = vchain[STAGES];
  assign out_tag   = tag_arr[STAGES];
  assign out_all   = out_valid & ~g_lvl[LW-1].g_reg.q_v[0];
  assign out_count = g_lvl[LW-1].g_reg.q_v[0] ? g_lvl[LW-1].g_reg.q_p : '0;

`ifdef CLZ_PIPE_NORM_EN
  assign out_norm = opd_arr[STAGES] << out_count;
`endif

endmodule

// File: tb/tb_clz_pipe.sv
// Directed self-checking bench for clz_pipe at WIDTH=16, STAGES=2, TAG_W=4.
// Normalised-output checks run only when CLZ_PIPE_NORM_EN is defined.
module tb_clz_pipe;
  localparam int WIDTH  = 16;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_count;
  logic             out_all;
  logic [TAG_W-1:0] out_tag;
`ifdef CLZ_PIPE_NORM_EN
  logic [WIDTH-1:0] out_norm;
`endif

  int checks = 0;
  int errors = 0;

  clz_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_all   (out_all),
    .out_tag   (out_tag)
`ifdef CLZ_PIPE_NORM_EN
    ,
    .out_norm  (out_norm)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", out_count); end
    checks++; if (out_all !== 1'b0) begin errors++; $display("FAIL reset_all got %b want 0", out_all); end
    checks++; if (out_tag !== 4'd0) begin errors++; $display("FAIL reset_tag got %0d want 0", out_tag); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_zeros();
    logic [15:0] dv [3];
    logic [3:0]  tv [3];
    logic [3:0]  cv [3];
    logic        av [3];
    dv = '{16'h0001, 16'h8000, 16'h0000};
    tv = '{4'd3, 4'd5, 4'd9};
    cv = '{4'd15, 4'd0, 4'd0};
    av = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = dv[i]; in_mode = 1'b0; in_tag = tv[i];
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zeros_in_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zeros_early[%0d] out_valid got %b want 0", i, out_valid); end
      tick();
      $display("zeros txn data=%h count=%0d all=%b tag=%0d", dv[i], out_count, out_all, out_tag);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zeros_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_count !== cv[i]) begin errors++; $display("FAIL zeros_count[%0d] got %0d want %0d", i, out_count, cv[i]); end
      checks++; if (out_all !== av[i]) begin errors++; $display("FAIL zeros_all[%0d] got %b want %b", i, out_all, av[i]); end
      checks++; if (out_tag !== tv[i]) begin errors++; $display("FAIL zeros_tag[%0d] got %0d want %0d", i, out_tag, tv[i]); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zeros_drain[%0d] out_valid got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_ones();
    logic [15:0] dv [3];
    logic [3:0]  tv [3];
    logic [3:0]  cv [3];
    logic        av [3];
    dv = '{16'hFF0F, 16'hFFFF, 16'h7FFF};
    tv = '{4'd1, 4'd2, 4'd4};
    cv = '{4'd8, 4'd0, 4'd0};
    av = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = dv[i]; in_mode = 1'b1; in_tag = tv[i];
      tick();
      in_valid = 1'b0;
      tick();
      $display("ones txn data=%h count=%0d all=%b tag=%0d", dv[i], out_count, out_all, out_tag);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_count !== cv[i]) begin errors++; $display("FAIL ones_count[%0d] got %0d want %0d", i, out_count, cv[i]); end
      checks++; if (out_all !== av[i]) begin errors++; $display("FAIL ones_all[%0d] got %b want %b", i, out_all, av[i]); end
      checks++; if (out_tag !== tv[i]) begin errors++; $display("FAIL ones_tag[%0d] got %0d want %0d", i, out_tag, tv[i]); end
      tick();
    end
    in_mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] dv [3];
    logic [3:0]  cv [3];
    dv = '{16'h0100, 16'h0010, 16'h0001};
    cv = '{4'd7, 4'd11, 4'd15};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        in_valid = 1'b1; in_data = dv[i]; in_mode = 1'b0; in_tag = 4'(i + 1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      if (i >= 2 && i <= 4) begin
        $display("b2b txn count=%0d tag=%0d", out_count, out_tag);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, out_valid); end
        checks++; if (out_count !== cv[i-2]) begin errors++; $display("FAIL b2b_count[%0d] got %0d want %0d", i, out_count, cv[i-2]); end
        checks++; if (out_tag !== 4'(i - 1)) begin errors++; $display("FAIL b2b_tag[%0d] got %0d want %0d", i, out_tag, i - 1); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d] out_valid got %b want 0", i, out_valid); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0400; in_mode = 1'b0; in_tag = 4'hA;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept0 got %b want 1", in_ready); end
    tick();
    in_data = 16'h0040; in_tag = 4'hB;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept1 got %b want 1", in_ready); end
    tick();
    in_data = 16'h0004; in_tag = 4'hC;
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_count !== 4'd5) begin errors++; $display("FAIL stall_hold_count[%0d] got %0d want 5", i, out_count); end
      checks++; if (out_tag !== 4'hA) begin errors++; $display("FAIL stall_hold_tag[%0d] got %0d want 10", i, out_tag); end
      checks++; if (out_all !== 1'b0) begin errors++; $display("FAIL stall_hold_all[%0d] got %b want 0", i, out_all); end
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    $display("stall txn count=%0d tag=%0d", out_count, out_tag);
    tick();
    in_valid = 1'b0;
    $display("stall txn count=%0d tag=%0d", out_count, out_tag);
    checks++; if (out_valid !== 1'b1 || out_count !== 4'd9 || out_tag !== 4'hB) begin
      errors++; $display("FAIL stall_second got v=%b c=%0d t=%0d want v=1 c=9 t=11", out_valid, out_count, out_tag);
    end
    tick();
    $display("stall txn count=%0d tag=%0d", out_count, out_tag);
    checks++; if (out_valid !== 1'b1 || out_count !== 4'd13 || out_tag !== 4'hC) begin
      errors++; $display("FAIL stall_third got v=%b c=%0d t=%0d want v=1 c=13 t=12", out_valid, out_count, out_tag);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_flight();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h0001; in_mode = 1'b0; in_tag = 4'd6;
    tick();
    in_data = 16'h0002; in_tag = 4'd7;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flight_pre_valid got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_async_valid got %b want 0", out_valid); end
    checks++; if (out_tag !== 4'd0) begin errors++; $display("FAIL flight_async_tag got %0d want 0", out_tag); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL flight_async_count got %0d want 0", out_count); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_stale[%0d] out_valid got %b want 0", i, out_valid); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flight_in_ready got %b want 1", in_ready); end
  endtask

`ifdef CLZ_PIPE_NORM_EN
  task automatic test_norm();
    logic [15:0] dv [3];
    logic        mv [3];
    logic [3:0]  cv [3];
    logic [15:0] nv [3];
    logic        av [3];
    dv = '{16'h00A3, 16'h0000, 16'hF0FF};
    mv = '{1'b0, 1'b0, 1'b1};
    cv = '{4'd8, 4'd0, 4'd4};
    nv = '{16'hA300, 16'h0000, 16'h0FF0};
    av = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = dv[i]; in_mode = mv[i]; in_tag = 4'(i);
      tick();
      in_valid = 1'b0;
      tick();
      $display("norm txn data=%h count=%0d norm=%h", dv[i], out_count, out_norm);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL norm_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_count !== cv[i]) begin errors++; $display("FAIL norm_count[%0d] got %0d want %0d", i, out_count, cv[i]); end
      checks++; if (out_norm !== nv[i]) begin errors++; $display("FAIL norm_value[%0d] got %h want %h", i, out_norm, nv[i]); end
      checks++; if (out_all !== av[i]) begin errors++; $display("FAIL norm_all[%0d] got %b want %b", i, out_all, av[i]); end
      tick();
    end
    in_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_back_to_back();
    test_stall();
    test_reset_flight();
`ifdef CLZ_PIPE_NORM_EN
    test_norm();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
